// File: rtl/sum_scatter_pkg.sv
// rtl/sum_scatter_pkg.sv - shared types and defaults for the sum scatter block
//
// Purpose: FSM state encoding, default widths and flit field offsets used by
// sum_scatter and its helper.
// Ports: none (package).
// Optional feature macro: SCATTER_MASK_EN (consumed by sum_scatter).

package sum_scatter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DEF_NUM_NODES = 16;
  localparam int DEF_ID_W      = 4;
  localparam int DEF_SUM_W     = 28;

  // Flit layout for the default widths: payload in the LSBs, dest id above it.
  localparam int PAYLOAD_LSB = 0;
  localparam int ID_LSB      = DEF_SUM_W;

endpackage

// File: rtl/sum_scatter_next_node_sel.sv
// rtl/sum_scatter_next_node_sel.sv - next set mask bit finder for masked scatter
//
// Purpose: combinational priority finder. Given the captured node mask and the
// current destination id, returns the next higher id whose mask bit is set.
// Ports:
//   mask    in  NUM_NODES  captured node mask
//   cur_id  in  ID_W       id of the flit currently offered
//   next_id out ID_W       next higher set index (cur_id when none)
//   last    out 1          no set bit above cur_id, so cur_id is the final flit
// Used only when SCATTER_MASK_EN is defined.

module next_node_sel
  import sum_scatter_pkg::*;
#(
  parameter int NUM_NODES = DEF_NUM_NODES,
  parameter int ID_W      = DEF_ID_W
) (
  input  logic [NUM_NODES-1:0] mask,
  input  logic [ID_W-1:0]      cur_id,
  output logic [ID_W-1:0]      next_id,
  output logic                 last
);

  // Scanning downward lets the lowest qualifying index overwrite the others.
  always_comb begin
    next_id = cur_id;
    last    = 1'b1;
    for (int i = NUM_NODES - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur_id))) begin
        next_id = ID_W'(i);
        last    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sum_scatter.sv
// rtl/sum_scatter.sv - distributes one aggregated sum as one flit per destination node
//
// Purpose: accepts a sum over a valid/ready handshake and serially emits
// NUM_NODES flits {dest_id, sum} toward the router injection port.
// Ports:
//   clk        in   1            system clock, rising edge
//   rst        in   1            synchronous active-high reset
//   in_valid   in   1            sum available
//   in_ready   out  1            block can accept a sum (IDLE decode)
//   in_sum     in   SUM_W        sum to distribute
//   node_mask  in   NUM_NODES    destination mask (SCATTER_MASK_EN only)
//   out_valid  out  1            flit valid (registered)
//   out_ready  in   1            router accepts the flit
//   out_flit   out  ID_W+SUM_W   {dest_id, payload} (registered)
//   done       out  1            pulse after the last flit of a sum is taken
// Optional feature macro: SCATTER_MASK_EN.

module sum_scatter
  import sum_scatter_pkg::*;
#(
  parameter int NUM_NODES = DEF_NUM_NODES,
  parameter int ID_W      = DEF_ID_W,
  parameter int SUM_W     = DEF_SUM_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_W-1:0]     in_sum,
`ifdef SCATTER_MASK_EN
  input  logic [NUM_NODES-1:0] node_mask,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_W+SUM_W-1:0] out_flit,
  output logic                 done
);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      cnt_q, cnt_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic                 out_valid_d;
  logic [ID_W+SUM_W-1:0] out_flit_d;
  logic                 done_d;

  logic                 accept;
  logic                 last_flit;
  logic [ID_W-1:0]      next_id;
  logic [ID_W-1:0]      first_id;
  logic                 any_set;

  assign accept = in_valid && (state_q == IDLE);

`ifdef SCATTER_MASK_EN
  logic [NUM_NODES-1:0] mask_q, mask_d;

  // Lowest set bit of the incoming mask is the first destination.
  always_comb begin
    first_id = '0;
    any_set  = 1'b0;
    for (int i = NUM_NODES - 1; i >= 0; i--) begin
      if (node_mask[i]) begin
        first_id = ID_W'(i);
        any_set  = 1'b1;
      end
    end
  end

  next_node_sel #(
    .NUM_NODES (NUM_NODES),
    .ID_W      (ID_W)
  ) u_next_node_sel (
    .mask    (mask_q),
    .cur_id  (cnt_q),
    .next_id (next_id),
    .last    (last_flit)
  );
`else
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_NODES - 1);

  assign first_id  = '0;
  assign any_set   = 1'b1;
  assign next_id   = cnt_q + ID_W'(1);
  assign last_flit = (cnt_q == LAST_ID);
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sum_q     <= '0;
      out_valid <= 1'b0;
      out_flit  <= '0;
      done      <= 1'b0;
`ifdef SCATTER_MASK_EN
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      out_valid <= out_valid_d;
      out_flit  <= out_flit_d;
      done      <= done_d;
`ifdef SCATTER_MASK_EN
      mask_q    <= mask_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && any_set) state_d = SEND;
      SEND: if (out_ready && last_flit) state_d = IDLE;
    endcase
  end

  // Output decode plus next values of the registered outputs, so that
  // out_valid/out_flit/done never depend combinationally on out_ready.
  always_comb begin
    in_ready    = (state_q == IDLE);
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    out_valid_d = out_valid;
    out_flit_d  = out_flit;
    done_d      = 1'b0;
`ifdef SCATTER_MASK_EN
    mask_d      = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          sum_d = in_sum;
          cnt_d = first_id;
`ifdef SCATTER_MASK_EN
          mask_d = node_mask;
`endif
          if (any_set) begin
            out_valid_d = 1'b1;
            out_flit_d  = {first_id, in_sum};
          end else begin
            // Empty mask: nothing to send, report completion straight away.
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_flit) begin
            out_valid_d = 1'b0;
            out_flit_d  = '0;
            done_d      = 1'b1;
          end else begin
            cnt_d      = next_id;
            out_flit_d = {next_id, sum_q};
          end
        end
      end
    endcase
  end

endmodule
